// File: rtl/atom_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle sequencer and decoder:
// state codes, next-PC selects, decoder type-vector bit positions and opcodes.
package atom_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;
  localparam logic [1:0] PC_SEL_TRAP   = 2'd3;

  // Bit positions inside the decoder's {R,I,L,S,J,B,U} type vector.
  localparam int TYPE_R = 6;
  localparam int TYPE_I = 5;
  localparam int TYPE_L = 4;
  localparam int TYPE_S = 3;
  localparam int TYPE_J = 2;
  localparam int TYPE_B = 1;
  localparam int TYPE_U = 0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // JAL and JALR differ only in this opcode bit.
  localparam int OPC_JAL_BIT = 3;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: +1 per inc pulse, wraps at 2^XLEN.
// Latency: count visible the cycle after inc. Backpressure: none.
// Reset: asynchronous active-low, clears to zero.
module retire_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [XLEN-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP (TRAP built only with ATOM_CTRL_TRAP_EN).
// Latency: 3..5 cycles per instruction plus memory waits. Backpressure: imem/dmem requests held until ack.
// Reset: asynchronous active-low; an in-flight instruction is dropped with no write strobe.
module core_ctrl_fsm
  import atom_ctrl_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int REG_FILE_ADDR_LEN = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [6:0]                   types,
  input  logic [6:0]                   opcode,
  input  logic [REG_FILE_ADDR_LEN-1:0] rd,
  input  logic                         branch_taken,
  output logic                         imem_req,
  input  logic                         imem_ack,
  output logic                         ir_we,
  output logic                         dmem_req,
  output logic                         dmem_we,
  input  logic                         dmem_ack,
  output logic                         rf_we,
  output logic                         pc_we,
  output logic [1:0]                   pc_sel,
  output logic                         busy,
  output logic                         retire,
  output logic [XLEN-1:0]              instret,
  output logic                         trap
);

  state_t state_q, state_nxt, boundary_nxt;

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^{opcode[6:OPC_JAL_BIT+1], opcode[OPC_JAL_BIT-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    boundary_nxt = run ? ST_FETCH : ST_IDLE;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    retire       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
`ifdef ATOM_CTRL_TRAP_EN
        state_nxt = (types == '0) ? ST_TRAP : ST_EXEC;
`else
        state_nxt = ST_EXEC;
`endif
      end

      ST_EXEC: begin
        if (types[TYPE_R] || types[TYPE_I] || types[TYPE_U] || types[TYPE_J]) begin
          state_nxt = ST_WB;
        end else if (types[TYPE_L] || types[TYPE_S]) begin
          state_nxt = ST_MEM;
        end else begin
          // Branches and undecodable words both finish here; only a taken branch redirects.
          pc_we     = 1'b1;
          retire    = 1'b1;
          pc_sel    = (types[TYPE_B] && branch_taken) ? PC_SEL_TARGET : PC_SEL_PLUS4;
          state_nxt = boundary_nxt;
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = types[TYPE_S];
        if (dmem_ack) begin
          if (types[TYPE_S]) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = boundary_nxt;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we  = (rd != '0);
        pc_we  = 1'b1;
        retire = 1'b1;
        if (types[TYPE_J]) begin
          pc_sel = opcode[OPC_JAL_BIT] ? PC_SEL_TARGET : PC_SEL_JALR;
        end
        state_nxt = boundary_nxt;
      end

`ifdef ATOM_CTRL_TRAP_EN
      ST_TRAP: begin
        trap      = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = PC_SEL_TRAP;
        state_nxt = boundary_nxt;
      end
`endif

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  retire_counter #(
    .XLEN (XLEN)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: a per-instruction vector table driven through a
// handshake responder, plus hand sequences for reset, run-drop and mid-fetch reset.
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  types;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        busy;
  logic        retire;
  logic [31:0] instret;
  logic        trap;

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  core_ctrl_fsm #(
    .XLEN              (32),
    .REG_FILE_ADDR_LEN (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .types        (types),
    .opcode       (opcode),
    .rd           (rd),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .busy         (busy),
    .retire       (retire),
    .instret      (instret),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] types;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       bt;
    int         imem_wait;
    int         dmem_wait;
    logic       noise;      // ack lines held high while not requested
    int         exp_cycles;
    int         exp_sel;
    int         exp_rf;
    int         exp_dwe;
    int         exp_dcyc;
    int         exp_retire;
    int         exp_trap;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input int idx, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL v%0d %s: got %0d expected %0d", idx, what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] t, input logic [6:0] op, input logic [4:0] r,
                              input logic bt, input int iw, input int dw, input logic nz,
                              input int cyc, input int sel, input int rf, input int dwe,
                              input int dcyc, input int ret, input int trp);
    vec_t v;
    v.types = t; v.opcode = op; v.rd = r; v.bt = bt;
    v.imem_wait = iw; v.dmem_wait = dw; v.noise = nz;
    v.exp_cycles = cyc; v.exp_sel = sel; v.exp_rf = rf; v.exp_dwe = dwe;
    v.exp_dcyc = dcyc; v.exp_retire = ret; v.exp_trap = trp;
    return v;
  endfunction

  // Runs one instruction starting in a FETCH cycle; ends after the cycle that strobes pc_we.
  task automatic exec_vec(input int idx, input vec_t v);
    int cyc = 0, fw = 0, dw = 0, dcyc = 0, ir_cyc = 0;
    int rf_seen = 0, dwe_seen = 0, ret_seen = 0, trap_seen = 0, sel = -1;
    bit done = 0;
    types = v.types; opcode = v.opcode; rd = v.rd; branch_taken = v.bt;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_req) begin imem_ack = (fw == v.imem_wait); fw++; end
      else imem_ack = v.noise;
      if (dmem_req) begin dmem_ack = (dw == v.dmem_wait); dw++; end
      else dmem_ack = v.noise;
      #1;
      if (ir_we && ir_cyc == 0) ir_cyc = cyc;
      if (rf_we) rf_seen = 1;
      if (dmem_req) begin dcyc++; if (dmem_we) dwe_seen = 1; end
      if (retire) ret_seen = 1;
      if (trap) trap_seen = 1;
      if (pc_we) begin done = 1; sel = int'(pc_sel); end
    end
    if (!done) check(idx, "timeout waiting for pc_we", 0, 1);
    @(posedge clk); #1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_instret += v.exp_retire;
    check(idx, "cycles", cyc, v.exp_cycles);
    check(idx, "ir_we cycle", ir_cyc, v.imem_wait + 1);
    check(idx, "pc_sel", sel, v.exp_sel);
    check(idx, "rf_we", rf_seen, v.exp_rf);
    check(idx, "dmem_we", dwe_seen, v.exp_dwe);
    check(idx, "dmem_req cycles", dcyc, v.exp_dcyc);
    check(idx, "retire", ret_seen, v.exp_retire);
    check(idx, "trap", trap_seen, v.exp_trap);
    check(idx, "instret", int'(instret), exp_instret);
  endtask

  initial begin
    //                 types        opcode       rd  bt iw dw nz  cyc sel rf dwe dcyc ret trp
    vecs[0]  = mk(7'b1000000, 7'b0110011, 5'd5, 0, 0, 0, 0,  4,  0, 1, 0, 0, 1, 0);
    vecs[1]  = mk(7'b0100000, 7'b0010011, 5'd0, 0, 0, 0, 1,  4,  0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(7'b0000001, 7'b0110111, 5'd7, 0, 2, 0, 0,  6,  0, 1, 0, 0, 1, 0);
    vecs[3]  = mk(7'b0010000, 7'b0000011, 5'd3, 0, 0, 3, 1,  8,  0, 1, 0, 4, 1, 0);
    vecs[4]  = mk(7'b0001000, 7'b0100011, 5'd9, 0, 0, 0, 0,  4,  0, 0, 1, 1, 1, 0);
    vecs[5]  = mk(7'b0000010, 7'b1100011, 5'd2, 1, 0, 0, 0,  3,  1, 0, 0, 0, 1, 0);
    vecs[6]  = mk(7'b0000010, 7'b1100011, 5'd2, 0, 0, 0, 0,  3,  0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(7'b0000100, 7'b1101111, 5'd0, 0, 0, 0, 0,  4,  1, 0, 0, 0, 1, 0);
    vecs[8]  = mk(7'b0000100, 7'b1100111, 5'd1, 0, 0, 0, 0,  4,  2, 1, 0, 0, 1, 0);
`ifdef ATOM_CTRL_TRAP_EN
    vecs[9]  = mk(7'b0000000, 7'b0000000, 5'd4, 1, 0, 0, 0,  3,  3, 0, 0, 0, 0, 1);
`else
    vecs[9]  = mk(7'b0000000, 7'b0000000, 5'd4, 1, 0, 0, 0,  3,  0, 0, 0, 0, 1, 0);
`endif
    vecs[10] = mk(7'b0001000, 7'b0100011, 5'd6, 0, 0, 2, 1,  6,  0, 0, 1, 3, 1, 0);
    vecs[11] = mk(7'b0010000, 7'b0000011, 5'd8, 0, 1, 0, 0,  6,  0, 1, 0, 1, 1, 0);

    // Reset with every input active: all outputs must stay low.
    rst_n = 1'b0; run = 1'b1; types = 7'b1000000; opcode = 7'b0110011; rd = 5'd5;
    branch_taken = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(-1, "reset outputs", int'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
                                     pc_sel, busy, retire, trap}), 0);
    check(-1, "reset instret", int'(instret), 0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    check(-1, "idle busy", int'(busy), 0);
    @(posedge clk); #1;   // IDLE -> FETCH with run=1

    for (int i = 0; i < 12; i++) exec_vec(i, vecs[i]);

    // run dropped while a load waits in MEM: load completes, then IDLE.
    begin
      int cyc = 0, dcnt = 0, rf_seen = 0;
      bit done = 0;
      types = 7'b0010000; opcode = 7'b0000011; rd = 5'd4;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc++;
        imem_ack = imem_req;
        if (dmem_req) begin run = 1'b0; dmem_ack = (dcnt == 1); dcnt++; end
        else dmem_ack = 1'b0;
        #1;
        if (rf_we) rf_seen = 1;
        if (pc_we) done = 1;
      end
      if (!done) check(-2, "timeout in run-drop load", 0, 1);
      @(posedge clk); #1;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      exp_instret++;
      check(-2, "run-drop cycles", cyc, 6);
      check(-2, "run-drop rf_we", rf_seen, 1);
      check(-2, "run-drop busy", int'(busy), 0);
      check(-2, "run-drop instret", int'(instret), exp_instret);
      @(negedge clk); #1;
      check(-2, "idle no fetch", int'({imem_req, busy}), 0);
    end

    // Reset pulsed during FETCH with an ack pending: immediate return to idle.
    run = 1'b1; types = 7'b1000000; rd = 5'd5;
    @(posedge clk); #1;
    check(-3, "fetch imem_req", int'(imem_req), 1);
    imem_ack = 1'b1;
    #1;
    check(-3, "fetch ir_we", int'(ir_we), 1);
    rst_n = 1'b0;
    #1;
    check(-3, "mid-fetch reset outputs", int'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
                                              pc_sel, busy, retire, trap}), 0);
    check(-3, "mid-fetch reset instret", int'(instret), 0);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
